// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: two single-write requesters (ALU, memory load)
// share one write port; a clear sequence zeroes all 8 registers on request.
module reg_write_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A_REQ,
  input  logic [2:0] A_ADDR,
  input  logic [7:0] A_DATA,
  output logic       A_ACK,
  input  logic       B_REQ,
  input  logic [2:0] B_ADDR,
  input  logic [7:0] B_DATA,
  output logic       B_ACK,
  input  logic       CLR_START,
  output logic       WRITE,
  output logic [2:0] INADDRESS,
  output logic [7:0] IN,
  output logic       BUSY
);

  // Handshake: a requester holds REQ/ADDR/DATA stable until it sees ACK high;
  // during its ACK cycle it counts as not requesting, so each request is
  // issued exactly once, and it may change REQ/ADDR/DATA at the edge ending ACK.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] count_q;
  logic       last_a_q;
  logic       write_q;
  logic [2:0] addr_q;
  logic [7:0] data_q;
  logic       a_ack_q;
  logic       b_ack_q;
  logic       busy_q;

  logic a_elig;
  logic b_elig;
  logic grant_a;
  logic grant_b;
  logic start_clr;
  logic clear_run;
  logic arb_en;

  assign a_elig  = A_REQ && !a_ack_q;
  assign b_elig  = B_REQ && !b_ack_q;
  assign grant_a = a_elig && (!b_elig || !FAIR || !last_a_q);
  assign grant_b = b_elig && !grant_a;

  assign start_clr = (state_q == IDLE) && CLR_START;
  assign clear_run = (state_q == CLEAR) && (count_q != 3'd7);
  // Arbitration happens in IDLE and also on the edge that leaves CLEAR.
  assign arb_en    = !start_clr && !clear_run;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      count_q  <= 3'd0;
      last_a_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 3'd0;
      data_q   <= 8'd0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_clr) begin
            state_q <= CLEAR;
            count_q <= 3'd0;
            write_q <= 1'b1;
            addr_q  <= 3'd0;
            data_q  <= 8'd0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_run) begin
            count_q <= count_q + 3'd1;
            write_q <= 1'b1;
            addr_q  <= count_q + 3'd1;
            data_q  <= 8'd0;
          end else begin
            state_q <= IDLE;
            count_q <= 3'd0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (arb_en && grant_a) begin
        write_q  <= 1'b1;
        addr_q   <= A_ADDR;
        data_q   <= A_DATA;
        a_ack_q  <= 1'b1;
        last_a_q <= 1'b1;
      end else if (arb_en && grant_b) begin
        write_q  <= 1'b1;
        addr_q   <= B_ADDR;
        data_q   <= B_DATA;
        b_ack_q  <= 1'b1;
        last_a_q <= 1'b0;
      end
    end
  end

  assign WRITE     = write_q;
  assign INADDRESS = addr_q;
  assign IN        = data_q;
  assign A_ACK     = a_ack_q;
  assign B_ACK     = b_ack_q;
  assign BUSY      = busy_q;

endmodule
